// File: rtl/ball_motion.sv
// ball_motion: per-frame ball position generator.
// On each frameTick the four button levels are sampled, a candidate move is
// bounds-checked and then probed against the tile map, one axis at a time.
// A move is committed only when it stays in bounds and neither leading
// corner of the ball lands on a wall tile.
// Optional feature macro: BALL_MOTION_ACCEL_EN. When defined, the step is
// an internal speed (1..4) that ramps up while a direction is held.
module ball_motion #(
    parameter int BALL_SIZE     = 16,
    parameter int STEP          = 1,
    parameter int START_X       = 480,
    parameter int START_Y       = 480,
    parameter int XMIN          = 65,
    parameter int XMAX          = 959,
    parameter int YMIN          = 0,
    parameter int YMAX          = 1023,
    parameter int WALL_TILE_MIN = 1
) (
    input  logic        clk108MHz,
    input  logic        CPU_RESETN,
    input  logic        frameTick,
    input  logic        upPressed,
    input  logic        downPressed,
    input  logic        leftPressed,
    input  logic        rightPressed,
    output logic [9:0]  tileAddr,
    input  logic [5:0]  tileType,
    output logic [10:0] ballX,
    output logic [10:0] ballY,
    output logic        busy,
    output logic        collision
);

    localparam logic [11:0] SIZE_M1 = 12'(BALL_SIZE - 1);
    localparam logic [11:0] XMIN_W  = 12'(XMIN);
    localparam logic [11:0] XMAX_W  = 12'(XMAX);
    localparam logic [11:0] YMIN_W  = 12'(YMIN);
    localparam logic [11:0] YMAX_W  = 12'(YMAX);
    localparam logic [5:0]  WALL_W  = 6'(WALL_TILE_MIN);

    typedef enum logic [2:0] {
        IDLE,
        X_PROBE0,
        X_PROBE1,
        X_CHECK,
        Y_PROBE0,
        Y_PROBE1,
        Y_CHECK
    } stateType;

    stateType state;
    stateType yEntryState;

    logic latUp, latDown, latLeft, latRight;
    logic goUp, goDown, goLeft, goRight;
    logic moveX, moveY;
    logic wallA, xForce, yForce;
    logic tileIsWall, xClear, yClear, xBlocked, yBlocked;
    logic [11:0] stepNow;
    logic [11:0] ballXW, ballYW;
    logic [11:0] nx, ny, leadCol, leadRow, xAfter, rowBottom, colRight;

`ifdef BALL_MOTION_ACCEL_EN
    logic [2:0] speed;
    logic [3:0] prevDir;
    logic [3:0] dirNow;

    // Step for this frame: ramps while the same direction pair is held, otherwise restarts at 1
    always_comb begin
        dirNow = {goUp, goDown, goLeft, goRight};
        if (state != IDLE) begin
            stepNow = {9'd0, speed};
        end else if (dirNow != 4'd0 && dirNow == prevDir) begin
            stepNow = (speed == 3'd4) ? 12'd4 : {9'd0, speed} + 12'd1;
        end else begin
            stepNow = 12'd1;
        end
    end
`else
    // Fixed step per frame
    always_comb begin
        stepNow = 12'(STEP);
    end
`endif

    // Candidate positions, bounds decisions and probe coordinates for both axes
    always_comb begin
        goLeft  = (state == IDLE) ? (leftPressed & ~rightPressed) : latLeft;
        goRight = (state == IDLE) ? (rightPressed & ~leftPressed) : latRight;
        goUp    = (state == IDLE) ? (upPressed & ~downPressed)    : latUp;
        goDown  = (state == IDLE) ? (downPressed & ~upPressed)    : latDown;
        moveX   = goLeft | goRight;
        moveY   = goUp | goDown;

        ballXW = {1'b0, ballX};
        ballYW = {1'b0, ballY};

        nx       = goLeft ? (ballXW - stepNow) : (ballXW + stepNow);
        xBlocked = goLeft ? (ballXW < XMIN_W + stepNow) : (nx + SIZE_M1 > XMAX_W);
        leadCol  = goLeft ? nx : (nx + SIZE_M1);

        tileIsWall = (tileType >= WALL_W);
        xClear     = !xForce && !wallA && !tileIsWall;
        yClear     = !yForce && !wallA && !tileIsWall;

        xAfter    = (state == X_CHECK && xClear) ? nx : ballXW;
        rowBottom = ballYW + SIZE_M1;
        colRight  = xAfter + SIZE_M1;

        ny       = goUp ? (ballYW - stepNow) : (ballYW + stepNow);
        yBlocked = goUp ? (ballYW < YMIN_W + stepNow) : (ny + SIZE_M1 > YMAX_W);
        leadRow  = goUp ? ny : (ny + SIZE_M1);

        if (!moveY) begin
            yEntryState = IDLE;
        end else if (yBlocked) begin
            yEntryState = Y_CHECK;
        end else begin
            yEntryState = Y_PROBE0;
        end
    end

    // Update sequencer: sample buttons, probe the leading corners per axis, commit or flag collision
    always_ff @(posedge clk108MHz or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state     <= IDLE;
            ballX     <= 11'(START_X);
            ballY     <= 11'(START_Y);
            busy      <= 1'b0;
            collision <= 1'b0;
            tileAddr  <= 10'd0;
            latUp     <= 1'b0;
            latDown   <= 1'b0;
            latLeft   <= 1'b0;
            latRight  <= 1'b0;
            wallA     <= 1'b0;
            xForce    <= 1'b0;
            yForce    <= 1'b0;
`ifdef BALL_MOTION_ACCEL_EN
            speed     <= 3'd1;
            prevDir   <= 4'd0;
`endif
        end else begin
            collision <= 1'b0;
            case (state)
                IDLE: begin
                    if (frameTick && !busy) begin
                        busy     <= 1'b1;
                        latUp    <= goUp;
                        latDown  <= goDown;
                        latLeft  <= goLeft;
                        latRight <= goRight;
`ifdef BALL_MOTION_ACCEL_EN
                        speed    <= stepNow[2:0];
                        prevDir  <= dirNow;
`endif
                        if (moveX) begin
                            xForce <= xBlocked;
                            if (xBlocked) begin
                                state <= X_CHECK;
                            end else begin
                                tileAddr <= {ballY[9:5], leadCol[9:5]};
                                state    <= X_PROBE0;
                            end
                        end else begin
                            yForce <= yBlocked;
                            state  <= yEntryState;
                            if (moveY && !yBlocked) begin
                                tileAddr <= {leadRow[9:5], xAfter[9:5]};
                            end
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                X_PROBE0: begin
                    tileAddr <= {rowBottom[9:5], leadCol[9:5]};
                    state    <= X_PROBE1;
                end
                X_PROBE1: begin
                    wallA <= tileIsWall;
                    state <= X_CHECK;
                end
                X_CHECK: begin
                    if (xClear) begin
                        ballX <= nx[10:0];
                    end else begin
                        collision <= 1'b1;
`ifdef BALL_MOTION_ACCEL_EN
                        prevDir   <= 4'd0;
`endif
                    end
                    yForce <= yBlocked;
                    state  <= yEntryState;
                    if (moveY && !yBlocked) begin
                        tileAddr <= {leadRow[9:5], xAfter[9:5]};
                    end
                    if (!moveY) begin
                        busy <= 1'b0;
                    end
                end
                Y_PROBE0: begin
                    tileAddr <= {leadRow[9:5], colRight[9:5]};
                    state    <= Y_PROBE1;
                end
                Y_PROBE1: begin
                    wallA <= tileIsWall;
                    state <= Y_CHECK;
                end
                Y_CHECK: begin
                    if (yClear) begin
                        ballY <= ny[10:0];
                    end else begin
                        collision <= 1'b1;
`ifdef BALL_MOTION_ACCEL_EN
                        prevDir   <= 4'd0;
`endif
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: randomized and directed checks of ball_motion against a
// frame-level behavioural model (positions, collisions, busy window).
`timescale 1ns/1ps
module tb_ball_motion;

    logic        clk108MHz = 1'b0;
    logic        CPU_RESETN;
    logic        frameTick;
    logic        upPressed, downPressed, leftPressed, rightPressed;
    logic [9:0]  tileAddr;
    logic [5:0]  tileType;
    logic [10:0] ballX, ballY;
    logic        busy, collision;

    logic [5:0] rom [0:1023];

    int checks = 0;
    int errors = 0;
    int mX, mY;
    int mRun, mPrevDir;

    ball_motion dut (
        .clk108MHz   (clk108MHz),
        .CPU_RESETN  (CPU_RESETN),
        .frameTick   (frameTick),
        .upPressed   (upPressed),
        .downPressed (downPressed),
        .leftPressed (leftPressed),
        .rightPressed(rightPressed),
        .tileAddr    (tileAddr),
        .tileType    (tileType),
        .ballX       (ballX),
        .ballY       (ballY),
        .busy        (busy),
        .collision   (collision)
    );

    // Pixel clock
    always #5 clk108MHz = ~clk108MHz;

    // Tile ROM with one cycle of read latency
    always @(posedge clk108MHz) tileType <= rom[tileAddr];

    // Global time limit so the bench always ends
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic bit isWall(int row, int col);
        return rom[(row / 32) * 32 + (col / 32)] >= 6'd1;
    endfunction

    // Reference model: what one accepted frame should do to the ball
    task automatic modelFrame(input bit u, input bit d, input bit l, input bit r, output int expColl);
        int dx, dy, s, nx, ny, lead, dir;
        bit blocked;
        dx = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
        dy = (d && !u) ? 1 : ((u && !d) ? -1 : 0);
        s = 1;
`ifdef BALL_MOTION_ACCEL_EN
        dir = (dx + 1) * 3 + (dy + 1);
        if (dir != 4 && dir == mPrevDir) mRun = (mRun >= 4) ? 4 : mRun + 1;
        else mRun = 1;
        s = mRun;
        mPrevDir = (dir == 4) ? -1 : dir;
`endif
        expColl = 0;
        if (dx != 0) begin
            nx = mX + dx * s;
            if ((dx < 0 && nx < 65) || (dx > 0 && nx + 15 > 959)) blocked = 1;
            else begin
                lead = (dx < 0) ? nx : nx + 15;
                blocked = isWall(mY, lead) || isWall(mY + 15, lead);
            end
            if (blocked) expColl++;
            else mX = nx;
        end
        if (dy != 0) begin
            ny = mY + dy * s;
            if ((dy < 0 && ny < 0) || (dy > 0 && ny + 15 > 1023)) blocked = 1;
            else begin
                lead = (dy < 0) ? ny : ny + 15;
                blocked = isWall(lead, mX) || isWall(lead, mX + 15);
            end
            if (blocked) expColl++;
            else mY = ny;
        end
`ifdef BALL_MOTION_ACCEL_EN
        if (expColl > 0) mPrevDir = -1;
`endif
    endtask

    // Drive one frame and observe collision pulses, busy cycles and probe activity
    task automatic applyStimulus(input bit u, input bit d, input bit l, input bit r,
                                 output int coll, output int busyCnt, output bit addrMoved);
        logic [9:0] addr0;
        {upPressed, downPressed, leftPressed, rightPressed} = {u, d, l, r};
        coll = 0;
        busyCnt = 0;
        addrMoved = 0;
        @(negedge clk108MHz);
        addr0 = tileAddr;
        frameTick = 1'b1;
        @(negedge clk108MHz);
        frameTick = 1'b0;
        {upPressed, downPressed, leftPressed, rightPressed} = 4'($urandom);
        for (int i = 0; i < 12; i++) begin
            if (busy) busyCnt++;
            if (collision) coll++;
            if (tileAddr !== addr0) addrMoved = 1;
            @(negedge clk108MHz);
        end
    endtask

    task automatic doReset();
        CPU_RESETN = 1'b0;
        repeat (3) @(negedge clk108MHz);
        CPU_RESETN = 1'b1;
        mX = 480; mY = 480; mRun = 0; mPrevDir = -1;
    endtask

    // Hold one button pattern for a number of frames, checking every frame
    task automatic test_walk(input string tag, input bit u, input bit d, input bit l, input bit r, input int frames);
        int expColl, coll, bc;
        bit moved;
        for (int f = 0; f < frames; f++) begin
            modelFrame(u, d, l, r, expColl);
            applyStimulus(u, d, l, r, coll, bc, moved);
            checks++;
            if (ballX !== 11'(mX)) begin errors++; $display("[TB] FAIL %s ballX frame %0d: got %0d expected %0d", tag, f, ballX, mX); end
            checks++;
            if (ballY !== 11'(mY)) begin errors++; $display("[TB] FAIL %s ballY frame %0d: got %0d expected %0d", tag, f, ballY, mY); end
            checks++;
            if (coll != expColl) begin errors++; $display("[TB] FAIL %s collisions frame %0d: got %0d expected %0d", tag, f, coll, expColl); end
            checks++;
            if (bc < 1 || bc > 7) begin errors++; $display("[TB] FAIL %s busy cycles frame %0d: got %0d expected 1..7", tag, f, bc); end
        end
    endtask

    task automatic test_reset();
        CPU_RESETN = 1'b0;
        repeat (3) @(negedge clk108MHz);
        checks++; if (ballX !== 11'd480) begin errors++; $display("[TB] FAIL reset ballX: got %0d expected 480", ballX); end
        checks++; if (ballY !== 11'd480) begin errors++; $display("[TB] FAIL reset ballY: got %0d expected 480", ballY); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b expected 0", busy); end
        checks++; if (collision !== 1'b0) begin errors++; $display("[TB] FAIL reset collision: got %b expected 0", collision); end
        checks++; if (tileAddr !== 10'd0) begin errors++; $display("[TB] FAIL reset tileAddr: got %0d expected 0", tileAddr); end
        CPU_RESETN = 1'b1;
        mX = 480; mY = 480; mRun = 0; mPrevDir = -1;
    endtask

    task automatic test_right_run();
        test_walk("rightRun", 0, 0, 0, 1, 10);
`ifndef BALL_MOTION_ACCEL_EN
        checks++; if (ballX !== 11'd490) begin errors++; $display("[TB] FAIL rightRun final ballX: got %0d expected 490", ballX); end
        checks++; if (ballY !== 11'd480) begin errors++; $display("[TB] FAIL rightRun final ballY: got %0d expected 480", ballY); end
`endif
    endtask

    task automatic test_back_to_back();
        int expColl;
        modelFrame(0, 0, 0, 1, expColl);
        {upPressed, downPressed, leftPressed, rightPressed} = 4'b0001;
        @(negedge clk108MHz); frameTick = 1'b1;
        @(negedge clk108MHz); frameTick = 1'b0;
        @(negedge clk108MHz); frameTick = 1'b1;
        @(negedge clk108MHz); frameTick = 1'b0;
        repeat (15) @(negedge clk108MHz);
        checks++; if (ballX !== 11'(mX)) begin errors++; $display("[TB] FAIL droppedTick ballX: got %0d expected %0d", ballX, mX); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL droppedTick busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        {upPressed, downPressed, leftPressed, rightPressed} = 4'b0001;
        @(negedge clk108MHz); frameTick = 1'b1;
        @(negedge clk108MHz); frameTick = 1'b0;
        @(negedge clk108MHz);
        CPU_RESETN = 1'b0;
        #1;
        checks++; if (ballX !== 11'd480) begin errors++; $display("[TB] FAIL midReset ballX: got %0d expected 480", ballX); end
        checks++; if (ballY !== 11'd480) begin errors++; $display("[TB] FAIL midReset ballY: got %0d expected 480", ballY); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midReset busy: got %b expected 0", busy); end
        checks++; if (tileAddr !== 10'd0) begin errors++; $display("[TB] FAIL midReset tileAddr: got %0d expected 0", tileAddr); end
        @(negedge clk108MHz);
        CPU_RESETN = 1'b1;
        mX = 480; mY = 480; mRun = 0; mPrevDir = -1;
    endtask

    task automatic test_wall();
        rom[15 * 32 + 16] = 6'd1;
        test_walk("wallApproach", 0, 0, 0, 1, 16);
        test_walk("wallHit", 0, 0, 0, 1, 1);
`ifndef BALL_MOTION_ACCEL_EN
        checks++; if (ballX !== 11'd496) begin errors++; $display("[TB] FAIL wall final ballX: got %0d expected 496", ballX); end
`endif
        rom[15 * 32 + 16] = 6'd0;
    endtask

    task automatic test_bounds();
        int expColl, coll, bc;
        bit moved;
        test_walk("walkLeft", 0, 0, 1, 0, mX - 65);
        modelFrame(0, 0, 1, 0, expColl);
        applyStimulus(0, 0, 1, 0, coll, bc, moved);
        checks++; if (coll != 1) begin errors++; $display("[TB] FAIL leftBound collisions: got %0d expected 1", coll); end
        checks++; if (ballX !== 11'd65) begin errors++; $display("[TB] FAIL leftBound ballX: got %0d expected 65", ballX); end
        checks++; if (moved) begin errors++; $display("[TB] FAIL leftBound tileAddr: got changed expected unchanged"); end
        test_walk("walkDown", 0, 1, 0, 0, 1008 - mY);
        modelFrame(0, 1, 0, 0, expColl);
        applyStimulus(0, 1, 0, 0, coll, bc, moved);
        checks++; if (coll != 1) begin errors++; $display("[TB] FAIL bottomBound collisions: got %0d expected 1", coll); end
        checks++; if (ballY !== 11'd1008) begin errors++; $display("[TB] FAIL bottomBound ballY: got %0d expected 1008", ballY); end
    endtask

    task automatic test_both_lr();
        int startX, startY;
        startX = mX;
        startY = mY;
        test_walk("leftRightUp", 1, 0, 1, 1, 5);
        checks++; if (ballX !== 11'(startX)) begin errors++; $display("[TB] FAIL leftRightUp ballX: got %0d expected %0d", ballX, startX); end
`ifndef BALL_MOTION_ACCEL_EN
        checks++; if (ballY !== 11'(startY - 5)) begin errors++; $display("[TB] FAIL leftRightUp ballY: got %0d expected %0d", ballY, startY - 5); end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 1024; i++) rom[i] = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
        doReset();
        for (int f = 0; f < 150; f++) begin
            test_walk("random", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1);
        end
        for (int i = 0; i < 1024; i++) rom[i] = 6'd0;
    endtask

`ifdef BALL_MOTION_ACCEL_EN
    task automatic test_accel();
        doReset();
        test_walk("accelRamp", 0, 0, 0, 1, 5);
        checks++; if (ballX !== 11'd494) begin errors++; $display("[TB] FAIL accel ballX: got %0d expected 494", ballX); end
        test_walk("accelRelease", 0, 0, 0, 0, 1);
        test_walk("accelRepress", 0, 0, 0, 1, 1);
        checks++; if (ballX !== 11'd495) begin errors++; $display("[TB] FAIL accel restart ballX: got %0d expected 495", ballX); end
    endtask
`endif

    initial begin
        frameTick = 1'b0;
        {upPressed, downPressed, leftPressed, rightPressed} = 4'b0000;
        for (int i = 0; i < 1024; i++) rom[i] = 6'd0;
        test_reset();
        test_right_run();
        test_back_to_back();
        test_reset_mid();
        test_wall();
        test_bounds();
        test_both_lr();
        test_random();
`ifdef BALL_MOTION_ACCEL_EN
        test_accel();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
